// File: rtl/feature_loader.sv
// feature_loader: streams feature words into a RAM, then raises acc_enable for a fixed window
// after a fixed idle delay following the last write.
module feature_loader #(
    parameter int DATA_W      = 128,
    parameter int ADDR_W      = 5,
    parameter int START_DELAY = 5,
    parameter int ENABLE_LEN  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              acc_enable,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int CNT_MAX = START_DELAY > ENABLE_LEN ? START_DELAY : ENABLE_LEN;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [ADDR_W:0] WL_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT, RUN} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_count;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_last;
    assign s_ready  = r_state == LOAD && words_loaded < r_count;
    assign busy     = r_state != IDLE;
    assign w_accept = s_valid && s_ready;
    assign w_last   = words_loaded + WL_ONE == r_count;
    // WAIT spans START_DELAY+1 cycles: its first cycle carries the final ram_we pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_base       <= '0;
            r_count      <= '0;
            r_cnt        <= '0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            acc_enable   <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
        end else begin
            ram_we <= w_accept;
            done   <= 1'b0;
            if (w_accept) begin
                ram_addr     <= r_base + words_loaded[ADDR_W-1:0];
                ram_wdata    <= s_data;
                words_loaded <= words_loaded + WL_ONE;
            end
            if (abort) begin
                r_state    <= IDLE;
                acc_enable <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (load_start) begin
                        r_base       <= base_addr;
                        r_count      <= word_count;
                        words_loaded <= '0;
                        r_cnt        <= '0;
                        r_state      <= word_count == '0 ? WAIT : LOAD;
                    end
                    LOAD: if (w_accept && w_last) begin
                        r_state <= WAIT;
                        r_cnt   <= '0;
                    end
                    WAIT: if (r_cnt == CNT_W'(START_DELAY)) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        acc_enable <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    RUN: if (r_cnt == CNT_W'(ENABLE_LEN - 1)) begin
                        r_state    <= IDLE;
                        acc_enable <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_feature_loader.sv
// tb_feature_loader: directed tests with a cycle-timeline reference model checked every cycle.
module tb_feature_loader;
    localparam int DW = 128;
    localparam int AW = 5;
    localparam int SD = 5;
    localparam int EL = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, abort, s_valid;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic [DW-1:0] s_data;
    logic          s_ready, ram_we, acc_enable, busy, done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [AW:0]   words_loaded;

    feature_loader #(.DATA_W(DW), .ADDR_W(AW), .START_DELAY(SD), .ENABLE_LEN(EL)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .base_addr(base_addr),
        .word_count(word_count), .abort(abort), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .acc_enable(acc_enable), .busy(busy), .done(done), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference model: a load is described by its phase (streaming or not), words taken,
    // and the cycle WAIT begins; acc/done/busy windows follow by arithmetic from that cycle.
    int            cyc = 0;
    bit            m_active = 0, m_in_load = 0, m_we = 0;
    int            m_k = 0, m_cnt = 0, m_base = 0, m_w = 0, m_done_cyc = -1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    bit            e_ready, e_busy, e_acc, e_done, accept;

    logic [AW-1:0] we_addr[$];
    logic [DW-1:0] we_data[$];
    int last_we_cyc, acc_rise_cyc, busy_rise_cyc, acc_cycles, done_cnt;
    bit prev_acc = 0, prev_busy = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 0; m_in_load = 0; m_we = 0; m_k = 0; m_cnt = 0; m_base = 0;
            m_w = 0; m_done_cyc = -1; m_addr = '0; m_wdata = '0;
        end
        e_ready = m_in_load && m_k < m_cnt;
        e_busy  = m_active && (m_in_load || cyc <= m_w + SD + EL);
        e_acc   = m_active && !m_in_load && cyc > m_w + SD && cyc <= m_w + SD + EL;
        e_done  = cyc == m_done_cyc;
        chk("s_ready", s_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("acc_enable", acc_enable, e_acc);
        chk("done", done, e_done);
        chk("ram_we", ram_we, m_we);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_wdata", ram_wdata, m_wdata);
        chk("words_loaded", words_loaded, m_k);
        if (ram_we) begin
            we_addr.push_back(ram_addr);
            we_data.push_back(ram_wdata);
            last_we_cyc = cyc;
        end
        if (acc_enable) begin
            if (!prev_acc) acc_rise_cyc = cyc;
            acc_cycles++;
        end
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        if (done) done_cnt++;
        prev_acc  = acc_enable;
        prev_busy = busy;
        if (!rst) begin
            accept = s_valid && e_ready;
            m_we = accept;
            if (accept) begin
                m_addr  = AW'((m_base + m_k) % (1 << AW));
                m_wdata = s_data;
                m_k++;
                if (m_k == m_cnt) begin
                    m_in_load = 0;
                    m_w = cyc + 1;
                end
            end
            if (abort) begin
                m_active = 0;
                m_in_load = 0;
            end else if (!e_busy && load_start) begin
                m_active = 1;
                m_base = int'(base_addr);
                m_cnt = int'(word_count);
                m_k = 0;
                m_in_load = m_cnt != 0;
                if (m_cnt == 0) m_w = cyc + 1;
            end else if (m_active && !m_in_load && cyc == m_w + SD + EL) begin
                m_active = 0;
                m_done_cyc = cyc + 1;
            end
        end
        cyc++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        we_addr.delete();
        we_data.delete();
        last_we_cyc = -1; acc_rise_cyc = -1; busy_rise_cyc = -1;
        acc_cycles = 0; done_cnt = 0;
    endtask

    task automatic start(input int b, input int n);
        base_addr = AW'(b);
        word_count = (AW+1)'(n);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic feed(input int n, input int first, input bit toggle);
        int sent = 0;
        int guard = 0;
        bit v = 1'b1;
        bit a;
        while (sent < n && guard < 200) begin
            s_valid = v;
            s_data = DW'(first + sent);
            a = s_valid && s_ready;
            tick();
            if (a) sent++;
            if (toggle) v = !v;
            guard++;
        end
        s_valid = 1'b0;
        chk("feed_words_sent", sent, n);
    endtask

    task automatic wait_done();
        int i = 0;
        while (done !== 1'b1 && i < 100) begin
            tick();
            i++;
        end
        chk("done_seen", done, 1);
        tick();
    endtask

    task automatic wait_acc();
        int i = 0;
        while (acc_enable !== 1'b1 && i < 100) begin
            tick();
            i++;
        end
        chk("acc_seen", acc_enable, 1);
    endtask

    initial begin
        int exp_a[8] = '{28, 29, 30, 31, 0, 1, 2, 3};
        rst = 1'b1; load_start = 0; abort = 0; s_valid = 0; s_data = '0;
        base_addr = '0; word_count = '0;
        clear_mon();
        #1;
        chk("rst_ram_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acc", acc_enable, 0);
        chk("rst_wl", words_loaded, 0);
        chk("rst_done", done, 0);
        #16 rst = 1'b0;
        tick(2);

        // 16 words from address 0
        clear_mon();
        start(0, 16);
        feed(16, 1, 0);
        wait_done();
        chk("t1_n_we", we_addr.size(), 16);
        chk("t1_addr0", we_addr[0], 0);
        chk("t1_addr15", we_addr[15], 15);
        chk("t1_data0", we_data[0], 1);
        chk("t1_data15", we_data[15], 16);
        chk("t1_acc_len", acc_cycles, 10);
        chk("t1_gap", acc_rise_cyc - last_we_cyc - 1, 5);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_wl", words_loaded, 16);

        // address wrap
        clear_mon();
        start(28, 8);
        feed(8, 100, 0);
        wait_done();
        chk("t2_n_we", we_addr.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_addr", we_addr[i], exp_a[i]);

        // s_valid toggling
        clear_mon();
        start(5, 4);
        feed(4, 200, 1);
        wait_done();
        chk("t3_n_we", we_addr.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_data", we_data[i], 200 + i);
        chk("t3_gap", acc_rise_cyc - last_we_cyc - 1, 5);

        // abort on third RUN cycle
        clear_mon();
        start(3, 2);
        feed(2, 50, 0);
        wait_acc();
        tick(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_acc_off", acc_enable, 0);
        chk("t4_busy_off", busy, 0);
        tick(5);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_acc_len", acc_cycles, 3);
        clear_mon();
        start(9, 1);
        feed(1, 77, 0);
        wait_done();
        chk("t4_n_we", we_addr.size(), 1);
        chk("t4_addr", we_addr[0], 9);
        chk("t4_data", we_data[0], 77);
        chk("t4_done_cnt", done_cnt, 1);

        // abort beats load_start in IDLE
        abort = 1'b1;
        base_addr = '0; word_count = 3; load_start = 1'b1;
        tick();
        abort = 1'b0; load_start = 1'b0;
        chk("t5_abort_wins", busy, 0);
        tick(2);

        // zero-word load
        clear_mon();
        start(0, 0);
        wait_done();
        chk("t6_n_we", we_addr.size(), 0);
        chk("t6_rise", acc_rise_cyc - busy_rise_cyc, SD + 1);
        chk("t6_acc_len", acc_cycles, 10);
        chk("t6_done_cnt", done_cnt, 1);

        // asynchronous reset mid-load
        clear_mon();
        start(0, 10);
        feed(6, 300, 0);
        chk("t7_wl_pre", words_loaded, 6);
        chk("t7_we_pre", ram_we, 1);
        #2 rst = 1'b1;
        #1;
        chk("t7_ram_we", ram_we, 0);
        chk("t7_busy", busy, 0);
        chk("t7_s_ready", s_ready, 0);
        chk("t7_wl", words_loaded, 0);
        chk("t7_addr", ram_addr, 0);
        chk("t7_wdata", ram_wdata, 0);
        #3 rst = 1'b0;
        tick(4);
        chk("t7_idle", busy, 0);

        // load_start during WAIT and RUN has no effect
        clear_mon();
        start(4, 2);
        feed(2, 400, 0);
        base_addr = 20; word_count = 5; load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wait_acc();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wait_done();
        tick(3);
        chk("t8_n_we", we_addr.size(), 2);
        chk("t8_addr1", we_addr[1], 5);
        chk("t8_wl", words_loaded, 2);
        chk("t8_done_cnt", done_cnt, 1);
        chk("t8_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
